// File: rtl/sprite_dispatcher_if.sv
// sprite_dispatcher_if: sprite queue head plus per-channel renderer job bus
// master: dispatcher side (pops queue, drives channel jobs); slave: queue/renderer side
// q_*: queue head and pop pulse; ch_*: flattened per-channel job, control and status
interface sprite_dispatcher_if #(
  parameter int NUM_CH = 4,
  parameter int ID_W = 8,
  parameter int COORD_W = 16,
  parameter int SCALE_W = 8
);
  logic q_valid;
  logic q_dequeue;
  logic [ID_W-1:0] q_id;
  logic [COORD_W-1:0] q_x;
  logic [COORD_W-1:0] q_y;
  logic [SCALE_W-1:0] q_scale;
  logic [NUM_CH-1:0] ch_start;
  logic [NUM_CH-1:0] ch_abort;
  logic [NUM_CH-1:0] ch_busy;
  logic [NUM_CH*ID_W-1:0] ch_id;
  logic [NUM_CH*COORD_W-1:0] ch_x;
  logic [NUM_CH*COORD_W-1:0] ch_y;
  logic [NUM_CH*SCALE_W-1:0] ch_scale;
  logic [NUM_CH-1:0] ch_finished;
  modport master (
    input q_valid, q_id, q_x, q_y, q_scale, ch_finished,
    output q_dequeue, ch_start, ch_abort, ch_busy, ch_id, ch_x, ch_y, ch_scale
  );
  modport slave (
    output q_valid, q_id, q_x, q_y, q_scale, ch_finished,
    input q_dequeue, ch_start, ch_abort, ch_busy, ch_id, ch_x, ch_y, ch_scale
  );
endinterface

// File: rtl/sprite_dispatcher.sv
// sprite_dispatcher: round-robin hand-off of queued sprite jobs to NUM_CH renderer channels
// clock, reset_n (async, active-low); frame_start flushes and arms; list_done marks end of list
// bus: queue pop + per-channel start/abort/busy/job registers; frame_done, jobs_issued status
module sprite_dispatcher #(
  parameter int NUM_CH = 4,
  parameter int ID_W = 8,
  parameter int COORD_W = 16,
  parameter int SCALE_W = 8,
  parameter int CNT_W = 16
) (
  input logic clock,
  input logic reset_n,
  input logic frame_start,
  input logic list_done,
  sprite_dispatcher_if.master bus,
  output logic frame_done,
  output logic [CNT_W-1:0] jobs_issued
);
  localparam int RR_W = $clog2(NUM_CH);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state;
  logic [RR_W-1:0] rr;
  logic [RR_W-1:0] idx;
  logic [RR_W-1:0] sel;
  logic found;
  logic dispatch;
  logic [NUM_CH-1:0] grant;
  // first free channel scanning upward from rr, wrapping at NUM_CH
  always_comb begin
    found = 1'b0;
    sel = '0;
    idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = RR_W'((int'(rr) + i) % NUM_CH);
      if (!found && !bus.ch_busy[idx]) begin
        found = 1'b1;
        sel = idx;
      end
    end
    // the queue head is stale while q_dequeue is high, hence the bubble
    dispatch = state == RUN && bus.q_valid && !bus.q_dequeue && found;
    grant = dispatch ? NUM_CH'(1) << sel : '0;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      rr <= '0;
      bus.q_dequeue <= 1'b0;
      bus.ch_start <= '0;
      bus.ch_abort <= '0;
      bus.ch_busy <= '0;
      bus.ch_id <= '0;
      bus.ch_x <= '0;
      bus.ch_y <= '0;
      bus.ch_scale <= '0;
      frame_done <= 1'b0;
      jobs_issued <= '0;
    end else begin
      bus.q_dequeue <= 1'b0;
      bus.ch_start <= '0;
      bus.ch_abort <= '0;
      if (frame_start) begin
        bus.ch_abort <= bus.ch_busy;
        bus.ch_busy <= '0;
        frame_done <= 1'b0;
        jobs_issued <= '0;
        rr <= '0;
        state <= RUN;
      end else begin
        // release uses the registered busy, so a freed channel is reusable one edge later
        bus.ch_busy <= (bus.ch_busy & ~bus.ch_finished) | grant;
        bus.ch_start <= grant;
        if (dispatch) begin
          bus.q_dequeue <= 1'b1;
          bus.ch_id[sel*ID_W +: ID_W] <= bus.q_id;
          bus.ch_x[sel*COORD_W +: COORD_W] <= bus.q_x;
          bus.ch_y[sel*COORD_W +: COORD_W] <= bus.q_y;
          bus.ch_scale[sel*SCALE_W +: SCALE_W] <= bus.q_scale;
          rr <= RR_W'((int'(sel) + 1) % NUM_CH);
          jobs_issued <= jobs_issued + CNT_W'(jobs_issued != '1);
        end
        if (state == RUN && list_done && !bus.q_valid && !bus.q_dequeue) state <= DRAIN;
        if (state == DRAIN && bus.ch_busy == '0) begin
          state <= DONE;
          frame_done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_sprite_dispatcher.sv
// tb_sprite_dispatcher: directed and randomized checks of sprite_dispatcher against a queue-based model
module tb_sprite_dispatcher;
  localparam int N = 4;
  localparam int IW = 8;
  localparam int CW = 16;
  localparam int SW = 8;
  localparam int NW = 3;
  localparam int CMAX = (1 << NW) - 1;
  typedef struct packed {
    logic [IW-1:0] id;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic [SW-1:0] sc;
  } job_t;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic frame_start = 1'b0;
  logic list_done = 1'b0;
  logic frame_done;
  logic [NW-1:0] jobs_issued;
  sprite_dispatcher_if #(.NUM_CH(N), .ID_W(IW), .COORD_W(CW), .SCALE_W(SW)) bus ();
  sprite_dispatcher #(.NUM_CH(N), .ID_W(IW), .COORD_W(CW), .SCALE_W(SW), .CNT_W(NW)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .frame_start(frame_start),
    .list_done(list_done),
    .bus(bus),
    .frame_done(frame_done),
    .jobs_issued(jobs_issued)
  );
  always #5 clock = ~clock;
  job_t jq[$];
  int n_checks = 0;
  int n_err = 0;
  bit m_busy[N];
  int m_rr, m_st, m_cnt;
  bit m_deq, m_done;
  logic [N-1:0] m_start, m_abort;
  job_t m_job[N];
  job_t j5;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic drive_q();
    bus.q_valid = jq.size() > 0;
    if (jq.size() > 0) begin
      bus.q_id = jq[0].id;
      bus.q_x = jq[0].x;
      bus.q_y = jq[0].y;
      bus.q_scale = jq[0].sc;
    end else begin
      bus.q_id = '0;
      bus.q_x = '0;
      bus.q_y = '0;
      bus.q_scale = '0;
    end
  endtask
  task automatic push();
    job_t j;
    j = job_t'(48'({$urandom(), $urandom()}));
    jq.push_back(j);
    drive_q();
  endtask
  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_busy[k] = 1'b0;
      m_job[k] = '0;
    end
    m_rr = 0;
    m_st = 0;
    m_cnt = 0;
    m_deq = 1'b0;
    m_done = 1'b0;
    m_start = '0;
    m_abort = '0;
  endtask
  // one clock edge of the reference behaviour; st: 0 idle, 1 run, 2 drain, 3 done
  task automatic model_edge();
    bit qv, od, any_busy;
    int g;
    if (!reset_n) begin
      model_reset();
      return;
    end
    qv = jq.size() > 0;
    od = m_deq;
    any_busy = 1'b0;
    g = -1;
    m_start = '0;
    m_abort = '0;
    m_deq = 1'b0;
    if (frame_start) begin
      for (int k = 0; k < N; k++) begin
        m_abort[k] = m_busy[k];
        m_busy[k] = 1'b0;
      end
      m_done = 1'b0;
      m_cnt = 0;
      m_rr = 0;
      m_st = 1;
      return;
    end
    for (int k = 0; k < N; k++) any_busy |= m_busy[k];
    if (m_st == 1 && qv && !od)
      for (int i = 0; i < N; i++)
        if (g < 0 && !m_busy[(m_rr + i) % N]) g = (m_rr + i) % N;
    for (int k = 0; k < N; k++) if (bus.ch_finished[k]) m_busy[k] = 1'b0;
    if (g >= 0) begin
      m_busy[g] = 1'b1;
      m_start[g] = 1'b1;
      m_deq = 1'b1;
      m_job[g] = jq[0];
      m_rr = (g + 1) % N;
      if (m_cnt < CMAX) m_cnt++;
    end
    if (m_st == 1 && list_done && !qv && !od) m_st = 2;
    else if (m_st == 2 && !any_busy) begin
      m_st = 3;
      m_done = 1'b1;
    end
  endtask
  task automatic compare();
    logic [N-1:0] b;
    for (int k = 0; k < N; k++) b[k] = m_busy[k];
    check("ch_busy", bus.ch_busy, b);
    check("ch_start", bus.ch_start, m_start);
    check("ch_abort", bus.ch_abort, m_abort);
    check("q_dequeue", bus.q_dequeue, m_deq);
    check("frame_done", frame_done, m_done);
    check("jobs_issued", jobs_issued, m_cnt);
    for (int k = 0; k < N; k++) begin
      check("ch_id", bus.ch_id[k*IW +: IW], m_job[k].id);
      check("ch_x", bus.ch_x[k*CW +: CW], m_job[k].x);
      check("ch_y", bus.ch_y[k*CW +: CW], m_job[k].y);
      check("ch_scale", bus.ch_scale[k*SW +: SW], m_job[k].sc);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    compare();
    if (m_deq && jq.size() > 0) begin
      void'(jq.pop_front());
      drive_q();
    end
  endtask
  initial begin
    bus.ch_finished = '0;
    model_reset();
    drive_q();
    tick();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) push();
    tick();
    tick();
    check("idle_no_start", bus.ch_start, 4'b0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      tick();
      check("grant_seq", bus.ch_start, (e % 2 == 1 && e <= 7) ? 4'(1 << ((e - 1) / 2)) : 4'b0);
      check("deq_seq", bus.q_dequeue, e % 2 == 1 && e <= 7);
    end
    check("issued4", jobs_issued, 4);
    j5 = jq[0];
    bus.ch_finished = 4'b0100;
    tick();
    bus.ch_finished = '0;
    tick();
    check("ch2_regrant", bus.ch_start, 4'b0100);
    check("ch2_id_job5", bus.ch_id[2*IW +: IW], j5.id);
    bus.ch_finished = 4'b0010;
    tick();
    bus.ch_finished = '0;
    tick();
    check("ch1_grant", bus.ch_start, 4'b0010);
    push();
    push();
    bus.ch_finished = 4'b1001;
    tick();
    bus.ch_finished = '0;
    tick();
    check("rr_ch3_first", bus.ch_start, 4'b1000);
    tick();
    check("rr_bubble", bus.ch_start, 4'b0000);
    tick();
    check("rr_ch0_next", bus.ch_start, 4'b0001);
    list_done = 1'b1;
    tick();
    tick();
    tick();
    check("drain_not_done", frame_done, 1'b0);
    bus.ch_finished = 4'b1111;
    tick();
    bus.ch_finished = '0;
    check("busy_cleared", bus.ch_busy, 4'b0);
    check("done_lag", frame_done, 1'b0);
    tick();
    check("done_rise", frame_done, 1'b1);
    list_done = 1'b0;
    for (int i = 0; i < 4; i++) push();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("done_cleared", frame_done, 1'b0);
    for (int e = 1; e <= 7; e++) tick();
    bus.ch_finished = 4'b0101;
    tick();
    bus.ch_finished = '0;
    push();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("abort_mask", bus.ch_abort, 4'b1010);
    check("abort_busy", bus.ch_busy, 4'b0);
    check("abort_cnt", jobs_issued, 0);
    tick();
    check("resume_ch0", bus.ch_start, 4'b0001);
    check("abort_one_cycle", bus.ch_abort, 4'b0);
    for (int c = 0; c < 4000; c++) begin
      frame_start = ($urandom % 97) == 0;
      if ($urandom % 20 == 0) list_done = ~list_done;
      bus.ch_finished = 4'($urandom) & 4'($urandom);
      if ($urandom % (((c / 300) % 2 == 0) ? 3 : 9) == 0 && jq.size() < 16) push();
      tick();
    end
    frame_start = 1'b1;
    list_done = 1'b0;
    bus.ch_finished = '0;
    for (int i = jq.size(); i < 4; i++) push();
    tick();
    frame_start = 1'b0;
    for (int e = 1; e <= 4; e++) tick();
    check("pre_rst_busy", bus.ch_busy, 4'b0011);
    check("pre_rst_qvalid", bus.q_valid, 1'b1);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("arst_busy", bus.ch_busy, 4'b0);
    check("arst_start", bus.ch_start, 4'b0);
    check("arst_deq", bus.q_dequeue, 1'b0);
    check("arst_cnt", jobs_issued, 0);
    check("arst_id", bus.ch_id, 32'h0);
    model_reset();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("post_rst_idle", bus.ch_start, 4'b0);
    check("post_rst_deq", bus.q_dequeue, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
